// File: rtl/replica_pkg.sv
// Shared replica-chain types, plus the host word packing used by the ordering read and write paths.
// A host word holds one city index per byte, city i in byte 7-i, with bit 7 of each byte always 0.
package replica_pkg;

   localparam int city_num     = 8;
   localparam int city_bits    = 7;
   localparam int city_div_log = 3;

   typedef logic [city_num-1:0][city_bits-1:0] replica_data_t;
   typedef logic [7:0][7:0]                    host_word_t;

   function automatic host_word_t pack_ordering(input replica_data_t word);
      host_word_t host;
      for (int i = 0; i < city_num; i++) begin
         host[city_num-1-i] = {1'b0, word[i]};
      end
      return host;
   endfunction

endpackage

// File: rtl/node_rd_fifo.sv
// Synchronous word FIFO with a registered head: a push into an empty FIFO shows on head one cycle later.
// full blocks pushes regardless of a same-cycle pop; pops of an empty FIFO are ignored.
module ordering_fifo
   import replica_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = replica_data_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head_valid,
   output T     head_data
);

   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic [AW:0]    wr_next;
   logic [AW:0]    rd_next;
   logic           do_push;
   logic           do_pop;

   // Pointer MSB differs only when the write side has lapped the read side.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wr_next = wr_ptr + {{AW{1'b0}}, do_push};
   assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         wr_ptr     <= wr_next;
         rd_ptr     <= rd_next;
         head_valid <= (wr_next != rd_next);
         // The incoming word bypasses memory when it becomes the new head.
         if (wr_next == rd_next) begin
            head_data <= '0;
         end else if (do_push && (wr_ptr == rd_next)) begin
            head_data <= push_data;
         end else begin
            head_data <= mem[rd_next[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/node_rd.sv
// Host read side of the node ordering: one exchange_shift per node, chain words buffered, repacked to bytes.
// Empty-FIFO latency is one cycle; in_ready drops only when the FIFO is full; stray chain words set a sticky error.
module node_rd
   import replica_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [city_div_log-1:0] ordering_num,
   input  logic                    ordering_read,
   input  logic                    in_valid,
   input  replica_data_t           in_data,
   output logic                    in_ready,
   output logic                    exchange_shift,
   output logic                    ordering_rvalid,
   output host_word_t              ordering_rdata,
   output logic                    read_busy,
   output logic                    ordering_err
);

   typedef enum logic [1:0] {IDLE, REQ, STREAM} state_t;

   localparam logic [city_div_log:0]   IN_ONE = {{city_div_log{1'b0}}, 1'b1};
   localparam logic [city_div_log-1:0] RD_ONE = {{(city_div_log-1){1'b0}}, 1'b1};

   state_t                  state;
   state_t                  state_next;
   logic [city_div_log-1:0] num_q;
   logic [city_div_log-1:0] rd_cnt;
   logic [city_div_log:0]   in_cnt;
   logic [city_div_log:0]   burst_len;
   logic                    in_done;
   logic                    push;
   logic                    pop;
   logic                    stray;
   logic                    fifo_full;
   logic                    fifo_empty;
   replica_data_t           head_data;

   assign burst_len = {1'b0, num_q} + IN_ONE;
   assign in_done   = (in_cnt == burst_len);
   assign push      = (state == STREAM) && in_valid && !fifo_full && !in_done;
   assign pop       = (state == STREAM) && ordering_read && ordering_rvalid;
   // Any chain word outside the requested burst window is dropped and flagged.
   assign stray     = in_valid && ((state != STREAM) || in_done);
   assign in_ready  = !fifo_full;
   assign read_busy = (state != IDLE);

   ordering_fifo #(
      .DEPTH (DEPTH),
      .T     (replica_data_t)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (in_data),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head_valid (ordering_rvalid),
      .head_data  (head_data)
   );

   assign ordering_rdata = pack_ordering(head_data);

   always_comb begin
      state_next     = state;
      exchange_shift = 1'b0;
      case (state)
         IDLE: begin
            if (ordering_read && fifo_empty) begin
               state_next = REQ;
            end
         end
         REQ: begin
            exchange_shift = 1'b1;
            state_next     = STREAM;
         end
         STREAM: begin
            if (pop && (rd_cnt == num_q)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         num_q        <= '0;
         in_cnt       <= '0;
         rd_cnt       <= '0;
         ordering_err <= 1'b0;
      end else begin
         state <= state_next;
         if (state == REQ) begin
            num_q  <= ordering_num;
            in_cnt <= '0;
            rd_cnt <= '0;
         end else begin
            if (push) begin
               in_cnt <= in_cnt + IN_ONE;
            end
            if (pop) begin
               rd_cnt <= rd_cnt + RD_ONE;
            end
         end
         if (stray) begin
            ordering_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_node_rd.sv
// Directed-plus-random bench for node_rd; expected words and FIFO occupancy come from a queue model.
module tb_node_rd;
   import replica_pkg::*;

   localparam int DEPTH = 4;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [city_div_log-1:0] ordering_num;
   logic                    ordering_read;
   logic                    in_valid;
   replica_data_t           in_data;
   logic                    in_ready;
   logic                    exchange_shift;
   logic                    ordering_rvalid;
   logic [7:0][7:0]         ordering_rdata;
   logic                    read_busy;
   logic                    ordering_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   node_rd #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .ordering_num    (ordering_num),
      .ordering_read   (ordering_read),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_ready        (in_ready),
      .exchange_shift  (exchange_shift),
      .ordering_rvalid (ordering_rvalid),
      .ordering_rdata  (ordering_rdata),
      .read_busy       (read_busy),
      .ordering_err    (ordering_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Host view of a chain word: byte b carries city 7-b.
   function automatic logic [63:0] host_of(input replica_data_t w);
      logic [63:0] r = '0;
      for (int c = 0; c < 8; c++) r[(7-c)*8 +: 7] = w[c];
      return r;
   endfunction

   task automatic burst(input string tag, input int num, input int vprob, input int rprob,
                        input int hold, input bit fixed, input bit exp_err);
      replica_data_t words[$];
      int pushed = 0;
      int popped = 0;
      int cyc = 0;
      bit push_now;
      bit pop_now;
      for (int k = 0; k <= num; k++) begin
         replica_data_t w;
         for (int c = 0; c < 8; c++) w[c] = fixed ? 7'(c) : 7'($urandom);
         words.push_back(w);
      end
      check({tag, "_idle_busy"}, 64'(read_busy), 64'd0);
      ordering_num  = num[city_div_log-1:0];
      ordering_read = 1'b1;
      step();
      ordering_read = 1'b0;
      check({tag, "_shift"}, 64'(exchange_shift), 64'd1);
      check({tag, "_busy"}, 64'(read_busy), 64'd1);
      step();
      check({tag, "_shift_once"}, 64'(exchange_shift), 64'd0);
      while (popped <= num && cyc < 1000) begin
         ordering_num  = city_div_log'($urandom);
         in_valid      = (pushed <= num) && ($urandom_range(1, 100) <= vprob);
         in_data       = in_valid ? words[pushed] : '0;
         ordering_read = (pushed >= hold) && ($urandom_range(1, 100) <= rprob);
         check({tag, "_in_ready"}, 64'(in_ready), 64'(pushed - popped < DEPTH));
         check({tag, "_rvalid"}, 64'(ordering_rvalid), 64'(pushed - popped > 0));
         check({tag, "_no_shift"}, 64'(exchange_shift), 64'd0);
         push_now = in_valid && in_ready;
         pop_now  = ordering_read && ordering_rvalid;
         if (pop_now) begin
            check({tag, "_rdata"}, ordering_rdata, host_of(words[popped]));
            if (fixed && popped == 0) check({tag, "_rdata_const"}, ordering_rdata, 64'h0001020304050607);
         end
         step();
         cyc++;
         if (push_now) pushed++;
         if (pop_now) popped++;
      end
      ordering_read = 1'b0;
      in_valid      = 1'b0;
      check({tag, "_words_done"}, 64'(popped), 64'(num + 1));
      check({tag, "_end_busy"}, 64'(read_busy), 64'd0);
      check({tag, "_end_rvalid"}, 64'(ordering_rvalid), 64'd0);
      check({tag, "_err"}, 64'(ordering_err), 64'(exp_err));
   endtask

   initial begin
      reset         = 1'b1;
      ordering_num  = '0;
      ordering_read = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      step();
      step();
      reset = 1'b0;
      check("rst_shift", 64'(exchange_shift), 64'd0);
      check("rst_rvalid", 64'(ordering_rvalid), 64'd0);
      check("rst_rdata", ordering_rdata, 64'd0);
      check("rst_busy", 64'(read_busy), 64'd0);
      check("rst_err", 64'(ordering_err), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Single-word node with cities 0..7.
      burst("t1", 0, 100, 100, 0, 1'b1, 1'b0);
      // Back-to-back four-word node with the host always reading.
      burst("t2", 3, 100, 100, 0, 1'b0, 1'b0);
      // Host idle until the FIFO fills, then drains all eight words.
      burst("t3", 7, 100, 100, DEPTH, 1'b0, 1'b0);
      // ordering_num is scrambled every streaming cycle; the sampled value rules.
      burst("t6", 3, 80, 70, 0, 1'b0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         burst("rnd", int'($urandom_range(0, 7)), 60, 50, 0, 1'b0, 1'b0);
      end

      // Stray chain word while idle.
      in_valid = 1'b1;
      in_data  = replica_data_t'({$urandom, $urandom});
      step();
      in_valid = 1'b0;
      check("t4_err", 64'(ordering_err), 64'd1);
      check("t4_rvalid", 64'(ordering_rvalid), 64'd0);
      check("t4_in_ready", 64'(in_ready), 64'd1);
      step();
      step();
      check("t4_err_held", 64'(ordering_err), 64'd1);
      burst("t4b", 2, 70, 70, 0, 1'b0, 1'b1);

      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t4_err_clr", 64'(ordering_err), 64'd0);

      // Reset in the middle of a four-word burst after two words.
      ordering_num  = 3'd3;
      ordering_read = 1'b1;
      step();
      ordering_read = 1'b0;
      check("t5_shift", 64'(exchange_shift), 64'd1);
      step();
      in_valid = 1'b1;
      in_data  = replica_data_t'({$urandom, $urandom});
      step();
      in_data  = replica_data_t'({$urandom, $urandom});
      step();
      in_valid = 1'b0;
      check("t5_rvalid_pre", 64'(ordering_rvalid), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_rvalid", 64'(ordering_rvalid), 64'd0);
      check("t5_rdata", ordering_rdata, 64'd0);
      check("t5_busy", 64'(read_busy), 64'd0);
      check("t5_shift0", 64'(exchange_shift), 64'd0);
      check("t5_err", 64'(ordering_err), 64'd0);
      check("t5_in_ready", 64'(in_ready), 64'd1);
      burst("t5b", 3, 90, 90, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
